// File: rtl/motion_profile_gen.sv
// motion_profile_gen
// Generates a per-second velocity command stream that moves a position
// tracker from a start position to a destination without overshoot, using a
// trapezoidal (or, for short moves, triangular) velocity profile.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   start_i         move request, sampled only while idle
//   abort_i         stop the current move immediately (ignored while idle)
//   start_pos_i     start position of the requested move
//   dest_pos_i      destination position of the requested move
//   vmax_i          velocity limit in units/s (0 is treated as 1)
//   acc_i           velocity change per second (0 is treated as 1)
//   busy_o          move in progress
//   vel_o           velocity command for the coming second
//   pos_o           modelled position
//   phase_o         0 idle/done, 1 accel, 2 cruise, 3 decel
//   elapsed_s_o     seconds since move start (saturating)
//   done_o          one-cycle pulse on arrival
//   aborted_o       one-cycle pulse on abort
module motion_profile_gen #(
  parameter int c_clkfreq = 100000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [9:0]  start_pos_i,
  input  logic [9:0]  dest_pos_i,
  input  logic [7:0]  vmax_i,
  input  logic [7:0]  acc_i,
  output logic        busy_o,
  output logic [7:0]  vel_o,
  output logic [9:0]  pos_o,
  output logic [1:0]  phase_o,
  output logic [15:0] elapsed_s_o,
  output logic        done_o,
  output logic        aborted_o
);

  localparam int TW = (c_clkfreq > 2) ? $clog2(c_clkfreq) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(c_clkfreq - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_reg, state_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic          busy_reg, busy_next;
  logic [7:0]    vel_reg, vel_next;
  logic [9:0]    pos_reg, pos_next;
  logic [1:0]    phase_reg, phase_next;
  logic [15:0]   elapsed_reg, elapsed_next;
  logic          done_reg, done_next;
  logic          aborted_reg, aborted_next;
  logic [9:0]    dest_reg, dest_next;
  logic [7:0]    vmax_reg, vmax_next;
  logic [7:0]    acc_reg, acc_next;

  // Per-tick arithmetic. While running, pos + vel never exceeds dest, so
  // rem stays within 0..1023 and the braking product cannot overflow.
  logic        tick;
  logic [10:0] p_sum;
  logic [10:0] rem;
  logic [15:0] v_sq;
  logic [19:0] brake;
  logic [8:0]  v_up;
  logic [7:0]  v_cand;
  logic [1:0]  cand_phase;
  logic [7:0]  v_new;
  logic [15:0] elapsed_inc;

  assign tick        = (state_reg == RUN) && (timer_reg == TIMER_LAST);
  assign p_sum       = {1'b0, pos_reg} + {3'b000, vel_reg};
  assign rem         = {1'b0, dest_reg} - p_sum;
  assign v_sq        = {8'd0, vel_reg} * {8'd0, vel_reg};
  assign brake       = 20'({acc_reg, 1'b0}) * 20'(rem);
  assign v_up        = {1'b0, vel_reg} + {1'b0, acc_reg};
  assign elapsed_inc = (elapsed_reg == 16'hFFFF) ? elapsed_reg : elapsed_reg + 16'd1;

  // Velocity candidate: brake once v^2 reaches the stopping budget 2*acc*rem,
  // otherwise accelerate toward vmax, otherwise cruise.
  always_comb begin
    v_cand     = vmax_reg;
    cand_phase = 2'd2;
    if ({4'd0, v_sq} >= brake) begin
      v_cand     = (vel_reg > acc_reg) ? vel_reg - acc_reg : 8'd1;
      cand_phase = 2'd3;
    end else if (vel_reg < vmax_reg) begin
      v_cand     = (v_up > {1'b0, vmax_reg}) ? vmax_reg : v_up[7:0];
      cand_phase = 2'd1;
    end
  end

  // Never command more than the remaining distance.
  assign v_new = ({3'b000, v_cand} > rem) ? rem[7:0] : v_cand;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      timer_reg   <= '0;
      busy_reg    <= 1'b0;
      vel_reg     <= 8'd0;
      pos_reg     <= 10'd0;
      phase_reg   <= 2'd0;
      elapsed_reg <= 16'd0;
      done_reg    <= 1'b0;
      aborted_reg <= 1'b0;
      dest_reg    <= 10'd0;
      vmax_reg    <= 8'd1;
      acc_reg     <= 8'd1;
    end else begin
      state_reg   <= state_next;
      timer_reg   <= timer_next;
      busy_reg    <= busy_next;
      vel_reg     <= vel_next;
      pos_reg     <= pos_next;
      phase_reg   <= phase_next;
      elapsed_reg <= elapsed_next;
      done_reg    <= done_next;
      aborted_reg <= aborted_next;
      dest_reg    <= dest_next;
      vmax_reg    <= vmax_next;
      acc_reg     <= acc_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    timer_next   = timer_reg;
    busy_next    = busy_reg;
    vel_next     = vel_reg;
    pos_next     = pos_reg;
    phase_next   = phase_reg;
    elapsed_next = elapsed_reg;
    done_next    = 1'b0;
    aborted_next = 1'b0;
    dest_next    = dest_reg;
    vmax_next    = vmax_reg;
    acc_next     = acc_reg;

    case (state_reg)
      IDLE: begin
        timer_next = '0;
        if (start_i) begin
          pos_next     = start_pos_i;
          elapsed_next = 16'd0;
          if (dest_pos_i > start_pos_i) begin
            dest_next  = dest_pos_i;
            vmax_next  = (vmax_i == 8'd0) ? 8'd1 : vmax_i;
            acc_next   = (acc_i == 8'd0) ? 8'd1 : acc_i;
            vel_next   = 8'd0;
            busy_next  = 1'b1;
            phase_next = 2'd1;
            state_next = RUN;
          end else begin
            // Nothing to travel: report arrival immediately.
            done_next = 1'b1;
          end
        end
      end

      RUN: begin
        if (abort_i) begin
          // Abort wins over a same-cycle tick; position and time freeze.
          timer_next   = '0;
          vel_next     = 8'd0;
          busy_next    = 1'b0;
          phase_next   = 2'd0;
          aborted_next = 1'b1;
          state_next   = IDLE;
        end else begin
          timer_next = tick ? '0 : timer_reg + 1'b1;
          if (tick) begin
            elapsed_next = elapsed_inc;
            if (rem == 11'd0) begin
              pos_next   = dest_reg;
              vel_next   = 8'd0;
              phase_next = 2'd0;
              busy_next  = 1'b0;
              done_next  = 1'b1;
              state_next = IDLE;
            end else begin
              pos_next   = p_sum[9:0];
              vel_next   = v_new;
              phase_next = cand_phase;
            end
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign busy_o      = busy_reg;
  assign vel_o       = vel_reg;
  assign pos_o       = pos_reg;
  assign phase_o     = phase_reg;
  assign elapsed_s_o = elapsed_reg;
  assign done_o      = done_reg;
  assign aborted_o   = aborted_reg;

endmodule
